// File: rtl/dcache_wb_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_wb_master_pkg
//  Description : Shared state encoding and Wishbone constants for the D$
//                line-transfer master.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_wb_master_pkg;

    // Bit 1 marks a bus beat and bit 0 selects the beat, so the datapath
    // uses the state bits directly as the beat select.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RESP  = 2'b01,
        BEAT0 = 2'b10,
        BEAT1 = 2'b11
    } state_t;

    localparam logic [3:0] WB_SEL_ALL    = 4'hF;
    localparam int         BEAT_BYTES    = 4;
    localparam int         LINE_OFFSET_W = 3;

endpackage
`default_nettype wire

// File: rtl/dcache_wb_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_wb_master_if
//  Description : Cache request/response and Wishbone bus signals of the
//                D$ line-transfer master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dcache_wb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [2*DATA_W-1:0]   req_wdata;
    logic                  resp_valid;
    logic [2*DATA_W-1:0]   resp_rdata;

    logic [DATA_W-1:0]     wbd_dat_o;
    logic [ADDR_W-1:0]     wbd_adr_o;
    logic [3:0]            wbd_sel_o;
    logic                  wbd_we_o;
    logic                  wbd_cyc_o;
    logic                  wbd_stb_o;
    logic [DATA_W-1:0]     wbd_dat_i;
    logic                  wbd_ack_i;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, wbd_dat_i, wbd_ack_i,
        output req_ready, resp_valid, resp_rdata,
        output wbd_dat_o, wbd_adr_o, wbd_sel_o, wbd_we_o, wbd_cyc_o, wbd_stb_o
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, wbd_dat_i, wbd_ack_i,
        input  req_ready, resp_valid, resp_rdata,
        input  wbd_dat_o, wbd_adr_o, wbd_sel_o, wbd_we_o, wbd_cyc_o, wbd_stb_o
    );
endinterface
`default_nettype wire

// File: rtl/dcache_wb_master.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_wb_master
//  Description : Moves one two-beat D$ line (refill or writeback) over a
//                Wishbone bus as a single back-to-back cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_wb_master
    import dcache_wb_master_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic           clk,
    input  wire logic           reset,
    dcache_wb_master_if.master  bus
);

    localparam logic [ADDR_W-1:0] LINE_MASK   = ~ADDR_W'((1 << LINE_OFFSET_W) - 1);
    localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(BEAT_BYTES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_base;
    logic [2*DATA_W-1:0]   r_wdata;
    logic [2*DATA_W-1:0]   r_rdata;

    logic                  w_accept;
    logic                  w_in_beat;
    logic                  w_beat_sel;

    logic                  w_req_ready;
    logic                  w_resp_valid;
    logic [DATA_W-1:0]     w_dat;
    logic [ADDR_W-1:0]     w_adr;
    logic [3:0]            w_sel;
    logic                  w_we;
    logic                  w_cyc;

    assign w_in_beat  = r_state[1];
    assign w_beat_sel = r_state[0];
    assign w_accept   = bus.req_valid && (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_state_nxt = BEAT0;
            BEAT0:   if (bus.wbd_ack_i) w_state_nxt = BEAT1;
            BEAT1:   if (bus.wbd_ack_i) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Read data is only captured on refills so a writeback leaves the last
    // refill line visible on resp_rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_base  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_base  <= bus.req_addr & LINE_MASK;
                r_wdata <= bus.req_wdata;
            end
            if (w_in_beat && bus.wbd_ack_i && !r_we) begin
                if (w_beat_sel) begin
                    r_rdata[2*DATA_W-1:DATA_W] <= bus.wbd_dat_i;
                end else begin
                    r_rdata[DATA_W-1:0] <= bus.wbd_dat_i;
                end
            end
        end
    end

    always_comb begin
        w_req_ready  = (r_state == IDLE);
        w_resp_valid = (r_state == RESP);
        w_cyc        = 1'b0;
        w_sel        = '0;
        w_we         = 1'b0;
        w_adr        = '0;
        w_dat        = '0;
        if (w_in_beat) begin
            w_cyc = 1'b1;
            w_sel = WB_SEL_ALL;
            w_we  = r_we;
            w_adr = w_beat_sel ? (r_base + BEAT_STRIDE) : r_base;
            w_dat = w_beat_sel ? r_wdata[2*DATA_W-1:DATA_W] : r_wdata[DATA_W-1:0];
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.wbd_cyc_o  = w_cyc;
    assign bus.wbd_stb_o  = w_cyc;
    assign bus.wbd_sel_o  = w_sel;
    assign bus.wbd_we_o   = w_we;
    assign bus.wbd_adr_o  = w_adr;
    assign bus.wbd_dat_o  = w_dat;

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_wb_master
//  Description : Directed, table-driven bench for dcache_wb_master.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_wb_master;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dcache_wb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dcache_wb_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [31:0] d0;
        logic [31:0] d1;
        int          w0;
        int          w1;
        logic [31:0] adr0;
        logic [31:0] adr1;
        logic [31:0] dat0;
        logic [31:0] dat1;
        logic [63:0] rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] adr,
                              input logic [31:0] dat, input logic we);
        chk({tag, ".cyc"},   64'(bus.wbd_cyc_o),  64'd1);
        chk({tag, ".stb"},   64'(bus.wbd_stb_o),  64'd1);
        chk({tag, ".adr"},   64'(bus.wbd_adr_o),  64'(adr));
        chk({tag, ".dat"},   64'(bus.wbd_dat_o),  64'(dat));
        chk({tag, ".sel"},   64'(bus.wbd_sel_o),  64'h0F);
        chk({tag, ".we"},    64'(bus.wbd_we_o),   64'(we));
        chk({tag, ".ready"}, 64'(bus.req_ready),  64'd0);
        chk({tag, ".resp"},  64'(bus.resp_valid), 64'd0);
    endtask

    // Entered in an IDLE cycle; returns in the IDLE cycle after RESP.
    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("vec%0d", idx);
        chk({t, ".ready_idle"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        step();
        bus.req_valid = 1'b0;
        bus.req_we    = ~v.we;
        bus.req_addr  = 32'hDEAD_0000;
        bus.req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 0; i < v.w0; i++) begin
            check_beat({t, ".b0wait"}, v.adr0, v.dat0, v.we);
            step();
        end
        check_beat({t, ".b0"}, v.adr0, v.dat0, v.we);
        bus.wbd_ack_i = 1'b1;
        bus.wbd_dat_i = v.d0;
        step();
        bus.wbd_ack_i = 1'b0;
        bus.wbd_dat_i = 32'h0BAD_0BAD;
        for (int i = 0; i < v.w1; i++) begin
            check_beat({t, ".b1wait"}, v.adr1, v.dat1, v.we);
            step();
        end
        check_beat({t, ".b1"}, v.adr1, v.dat1, v.we);
        bus.wbd_ack_i = 1'b1;
        bus.wbd_dat_i = v.d1;
        step();
        bus.wbd_ack_i = 1'b0;
        bus.wbd_dat_i = 32'h0BAD_0BAD;
        chk({t, ".resp_valid"}, 64'(bus.resp_valid), 64'd1);
        chk({t, ".resp_cyc"},   64'(bus.wbd_cyc_o),  64'd0);
        chk({t, ".resp_stb"},   64'(bus.wbd_stb_o),  64'd0);
        chk({t, ".resp_ready"}, 64'(bus.req_ready),  64'd0);
        chk({t, ".rdata"},      bus.resp_rdata,      v.rdata);
        step();
        chk({t, ".post_resp"},  64'(bus.resp_valid), 64'd0);
        chk({t, ".post_ready"}, 64'(bus.req_ready),  64'd1);
        chk({t, ".rdata_hold"}, bus.resp_rdata,      v.rdata);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_1000, 64'hDEADBEEF_CAFEF00D, 32'hAAAA_0001, 32'hBBBB_0002, 0, 0,
                    32'h0000_1000, 32'h0000_1004, 32'hCAFE_F00D, 32'hDEAD_BEEF, 64'hBBBB0002_AAAA0001};
        vecs[1] = '{1'b1, 32'h0000_2008, 64'h11112222_33334444, 32'h5555_5555, 32'h6666_6666, 3, 3,
                    32'h0000_2008, 32'h0000_200C, 32'h3333_4444, 32'h1111_2222, 64'hBBBB0002_AAAA0001};
        vecs[2] = '{1'b0, 32'h0000_3007, 64'h0, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0,
                    32'h0000_3000, 32'h0000_3004, 32'h0, 32'h0, 64'h9ABCDEF0_12345678};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 64'hA5A5A5A5_5A5A5A5A, 32'h0, 32'h0, 0, 2,
                    32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 64'h9ABCDEF0_12345678};
        vecs[4] = '{1'b0, 32'hFFFF_FFF8, 64'h0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 2, 1,
                    32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h0, 64'hF0F0F0F0_0F0F0F0F};

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.wbd_dat_i = '0;
        bus.wbd_ack_i = 1'b0;
        step();
        step();
        chk("rst.cyc",   64'(bus.wbd_cyc_o),  64'd0);
        chk("rst.stb",   64'(bus.wbd_stb_o),  64'd0);
        chk("rst.we",    64'(bus.wbd_we_o),   64'd0);
        chk("rst.sel",   64'(bus.wbd_sel_o),  64'd0);
        chk("rst.adr",   64'(bus.wbd_adr_o),  64'd0);
        chk("rst.dat",   64'(bus.wbd_dat_o),  64'd0);
        chk("rst.resp",  64'(bus.resp_valid), 64'd0);
        chk("rst.rdata", bus.resp_rdata,      64'd0);
        chk("rst.ready", 64'(bus.req_ready),  64'd1);
        reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        // req_valid held through a transfer with the address changing mid-flight.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_4000;
        bus.req_wdata = 64'h0;
        step();
        bus.req_addr  = 32'h0000_5000;
        check_beat("seqA.b0", 32'h0000_4000, 32'h0, 1'b0);
        bus.wbd_ack_i = 1'b1;
        bus.wbd_dat_i = 32'h0000_0001;
        step();
        bus.wbd_ack_i = 1'b0;
        check_beat("seqA.b1", 32'h0000_4004, 32'h0, 1'b0);
        bus.wbd_ack_i = 1'b1;
        bus.wbd_dat_i = 32'h0000_0002;
        step();
        bus.wbd_dat_i = 32'hFFFF_FFFF;
        chk("seqA.resp_valid", 64'(bus.resp_valid), 64'd1);
        chk("seqA.resp_ready", 64'(bus.req_ready),  64'd0);
        chk("seqA.rdata",      bus.resp_rdata,      64'h00000002_00000001);
        step();
        bus.wbd_ack_i = 1'b0;
        chk("seqA.idle_ready", 64'(bus.req_ready),  64'd1);
        chk("seqA.idle_cyc",   64'(bus.wbd_cyc_o),  64'd0);
        chk("seqA.idle_resp",  64'(bus.resp_valid), 64'd0);
        chk("seqA.idle_rdata", bus.resp_rdata,      64'h00000002_00000001);
        step();
        bus.req_valid = 1'b0;
        check_beat("seqA.n_b0", 32'h0000_5000, 32'h0, 1'b0);
        bus.wbd_ack_i = 1'b1;
        bus.wbd_dat_i = 32'h0000_0003;
        step();
        check_beat("seqA.n_b1", 32'h0000_5004, 32'h0, 1'b0);
        bus.wbd_dat_i = 32'h0000_0004;
        step();
        bus.wbd_ack_i = 1'b0;
        chk("seqA.n_resp",  64'(bus.resp_valid), 64'd1);
        chk("seqA.n_rdata", bus.resp_rdata,      64'h00000004_00000003);
        step();

        // Stray ack in IDLE, then reset while in BEAT1.
        bus.wbd_ack_i = 1'b1;
        bus.wbd_dat_i = 32'hFFFF_FFFF;
        step();
        bus.wbd_ack_i = 1'b0;
        chk("seqB.stray_cyc",   64'(bus.wbd_cyc_o),  64'd0);
        chk("seqB.stray_ready", 64'(bus.req_ready),  64'd1);
        chk("seqB.stray_resp",  64'(bus.resp_valid), 64'd0);
        chk("seqB.stray_rdata", bus.resp_rdata,      64'h00000004_00000003);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_6000;
        bus.req_we    = 1'b0;
        step();
        bus.req_valid = 1'b0;
        check_beat("seqB.b0", 32'h0000_6000, 32'h0, 1'b0);
        bus.wbd_ack_i = 1'b1;
        bus.wbd_dat_i = 32'h0000_0077;
        step();
        bus.wbd_ack_i = 1'b0;
        check_beat("seqB.b1", 32'h0000_6004, 32'h0, 1'b0);
        reset = 1'b1;
        step();
        chk("seqB.rst_cyc",   64'(bus.wbd_cyc_o),  64'd0);
        chk("seqB.rst_stb",   64'(bus.wbd_stb_o),  64'd0);
        chk("seqB.rst_resp",  64'(bus.resp_valid), 64'd0);
        chk("seqB.rst_ready", 64'(bus.req_ready),  64'd1);
        chk("seqB.rst_adr",   64'(bus.wbd_adr_o),  64'd0);
        chk("seqB.rst_rdata", bus.resp_rdata,      64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("seqB.after_resp", 64'(bus.resp_valid), 64'd0);
            chk("seqB.after_cyc",  64'(bus.wbd_cyc_o),  64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
